// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared decode definitions for the RV32I front end.
// Holds the default opcode constants, the instruction class enum, the packed
// decode/execute entry struct and the immediate-decode helpers used by
// instr_decode. No ports; import with `import rv32i_pkg::*;`.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE = 7'b0010011;

  typedef enum logic [1:0] {
    CLS_R       = 2'd0,
    CLS_I       = 2'd1,
    CLS_ILLEGAL = 2'd2
  } instr_class_e;

  // One decoded instruction as handed from decode to execute.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            wb_en;
  } id_ex_t;

  // Opcode values come in as arguments so a module can override them by parameter.
  function automatic instr_class_e classify(input logic [6:0] opc,
                                            input logic [6:0] r_opc,
                                            input logic [6:0] i_opc);
    if (opc == r_opc)      return CLS_R;
    else if (opc == i_opc) return CLS_I;
    else                   return CLS_ILLEGAL;
  endfunction

  function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  // Only register-immediate instructions carry an immediate in this decoder.
  function automatic logic [XLEN-1:0] decode_imm(input logic [XLEN-1:0] ir,
                                                 input instr_class_e cls);
    return (cls == CLS_I) ? imm_i(ir) : '0;
  endfunction

endpackage

// File: rtl/rf_2r1w.sv
// rf_2r1w -- 32 x 32-bit integer register file.
// Ports: clk, rst_n (sync, active-low, clears every register);
//        we/waddr/wdata : synchronous write port (writes to x0 are dropped);
//        raddr1/rdata1, raddr2/rdata2 : combinational read ports, x0 reads 0.
module rf_2r1w
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREG];

  // Write port; reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/instr_decode.sv
// instr_decode -- RV32I decode stage with a one-entry output register.
// Ports: clk, rst_n (sync, active-low);
//        IF_ID_VALID/IF_ID_READY/IF_ID_PC/IF_ID_IR : handshake from fetch;
//        WB_WE/WB_ADDR/WB_DATA                     : register write-back;
//        ID_EX_VALID/ID_EX_READY                   : handshake to execute;
//        ID_EX_PC/IR/RS1_DATA/RS2_DATA/IMM/RD/WB_EN: held decoded entry;
//        ILLEGAL_CNT : saturating count of accepted non-R/I instructions.
module instr_decode
  import rv32i_pkg::*;
#(
  parameter logic [6:0] R_TYPE = OPC_R_TYPE,
  parameter logic [6:0] I_TYPE = OPC_I_TYPE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IF_ID_VALID,
  output logic        IF_ID_READY,
  input  logic [31:0] IF_ID_PC,
  input  logic [31:0] IF_ID_IR,
  input  logic        WB_WE,
  input  logic [4:0]  WB_ADDR,
  input  logic [31:0] WB_DATA,
  output logic        ID_EX_VALID,
  input  logic        ID_EX_READY,
  output logic [31:0] ID_EX_PC,
  output logic [31:0] ID_EX_IR,
  output logic [31:0] ID_EX_RS1_DATA,
  output logic [31:0] ID_EX_RS2_DATA,
  output logic [31:0] ID_EX_IMM,
  output logic [4:0]  ID_EX_RD,
  output logic        ID_EX_WB_EN,
  output logic [7:0]  ILLEGAL_CNT
);

  logic         accept;
  logic         stall;
  logic [4:0]   rs1_addr;
  logic [4:0]   rs2_addr;
  logic [31:0]  rf_rs1;
  logic [31:0]  rf_rs2;
  instr_class_e cls;
  id_ex_t       dec;
  id_ex_t       entry_q;

  assign IF_ID_READY = !ID_EX_VALID || ID_EX_READY;
  assign accept      = IF_ID_VALID && IF_ID_READY;
  assign stall       = ID_EX_VALID && !ID_EX_READY;
  assign rs1_addr    = IF_ID_IR[19:15];
  assign rs2_addr    = IF_ID_IR[24:20];

  rf_2r1w u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (WB_WE),
    .waddr  (WB_ADDR),
    .wdata  (WB_DATA),
    .raddr1 (rs1_addr),
    .rdata1 (rf_rs1),
    .raddr2 (rs2_addr),
    .rdata2 (rf_rs2)
  );

  // Build the entry for the offered instruction. A write-back landing on the
  // same edge is forwarded so the operand is not one write stale.
  always_comb begin
    dec          = '0;
    cls          = classify(IF_ID_IR[6:0], R_TYPE, I_TYPE);
    dec.pc       = IF_ID_PC;
    dec.ir       = IF_ID_IR;
    dec.rd       = IF_ID_IR[11:7];
    dec.imm      = decode_imm(IF_ID_IR, cls);
    dec.wb_en    = (cls != CLS_ILLEGAL) && (IF_ID_IR[11:7] != 5'd0);
    dec.rs1_data = rf_rs1;
    dec.rs2_data = rf_rs2;
    if (WB_WE && (WB_ADDR != 5'd0) && (WB_ADDR == rs1_addr)) dec.rs1_data = WB_DATA;
    if (WB_WE && (WB_ADDR != 5'd0) && (WB_ADDR == rs2_addr)) dec.rs2_data = WB_DATA;
    if (cls == CLS_I) dec.rs2_data = '0;
  end

  // Output register. While execute stalls, a write-back to one of the held
  // sources refreshes the held operand so it does not go stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q     <= '0;
      ID_EX_VALID <= 1'b0;
      ILLEGAL_CNT <= '0;
    end else if (accept) begin
      entry_q     <= dec;
      ID_EX_VALID <= 1'b1;
      if ((cls == CLS_ILLEGAL) && (ILLEGAL_CNT != 8'hFF)) ILLEGAL_CNT <= ILLEGAL_CNT + 8'd1;
    end else begin
      if (ID_EX_READY) ID_EX_VALID <= 1'b0;
      if (stall && WB_WE && (WB_ADDR != 5'd0)) begin
        if (WB_ADDR == entry_q.ir[19:15]) entry_q.rs1_data <= WB_DATA;
        if ((WB_ADDR == entry_q.ir[24:20]) && (entry_q.ir[6:0] != I_TYPE))
          entry_q.rs2_data <= WB_DATA;
      end
    end
  end

  assign ID_EX_PC       = entry_q.pc;
  assign ID_EX_IR       = entry_q.ir;
  assign ID_EX_RS1_DATA = entry_q.rs1_data;
  assign ID_EX_RS2_DATA = entry_q.rs2_data;
  assign ID_EX_IMM      = entry_q.imm;
  assign ID_EX_RD       = entry_q.rd;
  assign ID_EX_WB_EN    = entry_q.wb_en;

endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode -- scoreboard bench for instr_decode.
// Stimulus pushes hand-computed entries into a queue; a monitor pops one each
// time execute consumes a held entry and compares every field.
module tb_instr_decode;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wb;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        IF_ID_VALID;
  logic        IF_ID_READY;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_IR;
  logic        WB_WE;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        ID_EX_VALID;
  logic        ID_EX_READY;
  logic [31:0] ID_EX_PC;
  logic [31:0] ID_EX_IR;
  logic [31:0] ID_EX_RS1_DATA;
  logic [31:0] ID_EX_RS2_DATA;
  logic [31:0] ID_EX_IMM;
  logic [4:0]  ID_EX_RD;
  logic        ID_EX_WB_EN;
  logic [7:0]  ILLEGAL_CNT;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  instr_decode dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IF_ID_VALID    (IF_ID_VALID),
    .IF_ID_READY    (IF_ID_READY),
    .IF_ID_PC       (IF_ID_PC),
    .IF_ID_IR       (IF_ID_IR),
    .WB_WE          (WB_WE),
    .WB_ADDR        (WB_ADDR),
    .WB_DATA        (WB_DATA),
    .ID_EX_VALID    (ID_EX_VALID),
    .ID_EX_READY    (ID_EX_READY),
    .ID_EX_PC       (ID_EX_PC),
    .ID_EX_IR       (ID_EX_IR),
    .ID_EX_RS1_DATA (ID_EX_RS1_DATA),
    .ID_EX_RS2_DATA (ID_EX_RS2_DATA),
    .ID_EX_IMM      (ID_EX_IMM),
    .ID_EX_RD       (ID_EX_RD),
    .ID_EX_WB_EN    (ID_EX_WB_EN),
    .ILLEGAL_CNT    (ILLEGAL_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return #1 after the closing rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic exr);
    IF_ID_VALID = v;
    IF_ID_PC    = pc;
    IF_ID_IR    = ir;
    WB_WE       = we;
    WB_ADDR     = wa;
    WB_DATA     = wd;
    ID_EX_READY = exr;
    @(posedge clk);
    #1;
  endtask

  task automatic expectEntry(input logic [31:0] pc, input logic [31:0] ir,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [4:0] rd, input logic wb);
    exp_t e;
    e.pc = pc; e.ir = ir; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rd = rd; e.wb = wb;
    sb.push_back(e);
  endtask

  // Monitor: an entry is consumed when it is valid and execute is ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ID_EX_VALID === 1'b1 && ID_EX_READY === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected actual=pc 0x%08h required=no entry", ID_EX_PC);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_pc",    ID_EX_PC,       e.pc);
        checkOutput("sb_ir",    ID_EX_IR,       e.ir);
        checkOutput("sb_rs1",   ID_EX_RS1_DATA, e.rs1);
        checkOutput("sb_rs2",   ID_EX_RS2_DATA, e.rs2);
        checkOutput("sb_imm",   ID_EX_IMM,      e.imm);
        checkOutput("sb_rd",    {27'd0, ID_EX_RD},    {27'd0, e.rd});
        checkOutput("sb_wb_en", {31'd0, ID_EX_WB_EN}, {31'd0, e.wb});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ir;
    rst_n = 1'b0;
    IF_ID_VALID = 1'b0; IF_ID_PC = '0; IF_ID_IR = '0;
    WB_WE = 1'b0; WB_ADDR = '0; WB_DATA = '0; ID_EX_READY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid",   {31'd0, ID_EX_VALID}, 32'd0);
    checkOutput("rst_illegal", {24'd0, ILLEGAL_CNT}, 32'd0);
    checkOutput("rst_pc",      ID_EX_PC, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_if_ready", {31'd0, IF_ID_READY}, 32'd1);

    // Write-back x5 then ADD x3,x5,x0.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h0000_1234, 1'b1);
    ir = enc_r(5'd3, 5'd5, 5'd0);
    expectEntry(32'h100, ir, 32'h0000_1234, 32'h0, 32'h0, 5'd3, 1'b1);
    applyStimulus(1'b1, 32'h100, ir, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("add_valid", {31'd0, ID_EX_VALID}, 32'd1);

    // ADDI x1,x2,-1 with x2=7 written on the same edge.
    ir = enc_i(12'hFFF, 5'd2, 5'd1);
    expectEntry(32'h104, ir, 32'd7, 32'h0, 32'hFFFF_FFFF, 5'd1, 1'b1);
    applyStimulus(1'b1, 32'h104, ir, 1'b1, 5'd2, 32'd7, 1'b1);

    // ADD x4,x6,x2 then three stalled cycles; x6 written mid-stall.
    ir = enc_r(5'd4, 5'd6, 5'd2);
    expectEntry(32'h108, ir, 32'h0000_00A5, 32'd7, 32'h0, 5'd4, 1'b1);
    applyStimulus(1'b1, 32'h108, ir, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h10C, 32'h0000_007F, (i == 1), 5'd6, 32'h0000_00A5, 1'b0);
      checkOutput("stall_if_ready", {31'd0, IF_ID_READY}, 32'd0);
      checkOutput("stall_valid",    {31'd0, ID_EX_VALID}, 32'd1);
      checkOutput("stall_pc",       ID_EX_PC, 32'h108);
      checkOutput("stall_ir",       ID_EX_IR, ir);
      checkOutput("stall_rs2",      ID_EX_RS2_DATA, 32'd7);
      checkOutput("stall_rd",       {27'd0, ID_EX_RD}, 32'd4);
      checkOutput("stall_rs1",      ID_EX_RS1_DATA, (i >= 1) ? 32'h0000_00A5 : 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("drain_valid", {31'd0, ID_EX_VALID}, 32'd0);
    checkOutput("no_illegal",  {24'd0, ILLEGAL_CNT}, 32'd0);

    // Back-to-back accepts, one entry per cycle.
    ir = enc_i(12'd5, 5'd0, 5'd7);
    expectEntry(32'h200, ir, 32'h0, 32'h0, 32'd5, 5'd7, 1'b1);
    applyStimulus(1'b1, 32'h200, ir, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("b2b_valid0", {31'd0, ID_EX_VALID}, 32'd1);
    ir = enc_r(5'd8, 5'd5, 5'd2);
    expectEntry(32'h204, ir, 32'h0000_1234, 32'd7, 32'h0, 5'd8, 1'b1);
    applyStimulus(1'b1, 32'h204, ir, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("b2b_valid1", {31'd0, ID_EX_VALID}, 32'd1);
    ir = enc_i(12'h800, 5'd6, 5'd9);
    expectEntry(32'h208, ir, 32'h0000_00A5, 32'h0, 32'hFFFF_F800, 5'd9, 1'b1);
    applyStimulus(1'b1, 32'h208, ir, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("b2b_valid2", {31'd0, ID_EX_VALID}, 32'd1);
    ir = enc_r(5'd0, 5'd5, 5'd5);
    expectEntry(32'h20C, ir, 32'h0000_1234, 32'h0000_1234, 32'h0, 5'd0, 1'b0);
    applyStimulus(1'b1, 32'h20C, ir, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("b2b_valid3", {31'd0, ID_EX_VALID}, 32'd1);
    ir = 32'h0043_2503;
    expectEntry(32'h210, ir, 32'h0000_00A5, 32'h0, 32'h0, 5'd10, 1'b0);
    applyStimulus(1'b1, 32'h210, ir, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("b2b_valid4", {31'd0, ID_EX_VALID}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("b2b_drain",  {31'd0, ID_EX_VALID}, 32'd0);
    checkOutput("illegal_one", {24'd0, ILLEGAL_CNT}, 32'd1);

    // 300 illegal words: the counter must saturate.
    for (int i = 0; i < 300; i++) begin
      expectEntry(32'h1000 + 32'(i) * 4, 32'h0000_007F, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
      applyStimulus(1'b1, 32'h1000 + 32'(i) * 4, 32'h0000_007F, 1'b0, 5'd0, 32'h0, 1'b1);
      if (i == 199) checkOutput("illegal_mid", {24'd0, ILLEGAL_CNT}, 32'd201);
    end
    checkOutput("illegal_sat",   {24'd0, ILLEGAL_CNT}, 32'd255);
    checkOutput("illegal_wb_en", {31'd0, ID_EX_WB_EN}, 32'd0);

    // Reset while an entry is held and another is offered.
    applyStimulus(1'b1, 32'h300, enc_r(5'd10, 5'd5, 5'd2), 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("pre_rst_valid", {31'd0, ID_EX_VALID}, 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h304, enc_r(5'd11, 5'd5, 5'd2), 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1);
    checkOutput("mid_rst_valid",   {31'd0, ID_EX_VALID}, 32'd0);
    checkOutput("mid_rst_illegal", {24'd0, ILLEGAL_CNT}, 32'd0);
    checkOutput("mid_rst_pc",      ID_EX_PC, 32'h0);
    checkOutput("mid_rst_rs1",     ID_EX_RS1_DATA, 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel2_if_ready", {31'd0, IF_ID_READY}, 32'd1);
    ir = enc_r(5'd12, 5'd5, 5'd2);
    expectEntry(32'h400, ir, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1);
    applyStimulus(1'b1, 32'h400, ir, 1'b0, 5'd0, 32'h0, 1'b1);
    ir = enc_i(12'd3, 5'd7, 5'd13);
    expectEntry(32'h404, ir, 32'h0, 32'h0, 32'd3, 5'd13, 1'b1);
    applyStimulus(1'b1, 32'h404, ir, 1'b0, 5'd0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("end_valid",   {31'd0, ID_EX_VALID}, 32'd0);
    checkOutput("sb_leftover", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have parameter R_TYPE, default 7'b0110011, register-register opcode.
REQ-002 SHALL have parameter I_TYPE, default 7'b0010011, register-immediate opcode.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port IF_ID_VALID  input  1  fetch offers an instruction.
REQ-006 SHALL have port IF_ID_READY  output  1  decode accepts the offered instruction.
REQ-007 SHALL have port IF_ID_PC  input  32  PC of the offered instruction.
REQ-008 SHALL have port IF_ID_IR  input  32  offered instruction word.
REQ-009 SHALL have port WB_WE  input  1  write-back register write enable.
REQ-010 SHALL have port WB_ADDR  input  5  write-back destination register.
REQ-011 SHALL have port WB_DATA  input  32  write-back data.
REQ-012 SHALL have port ID_EX_VALID  output  1  decoded entry held for execute.
REQ-013 SHALL have port ID_EX_READY  input  1  execute consumes the held entry.
REQ-014 SHALL have ports ID_EX_PC and ID_EX_IR  output  32 each  PC and IR of the held entry.
REQ-015 SHALL have ports ID_EX_RS1_DATA and ID_EX_RS2_DATA  output  32 each  source operands.
REQ-016 SHALL have port ID_EX_IMM  output  32  decoded immediate.
REQ-017 SHALL have port ID_EX_RD  output  5  destination register, IR[11:7].
REQ-018 SHALL have port ID_EX_WB_EN  output  1  entry writes rd on retirement.
REQ-019 SHALL have port ILLEGAL_CNT  output  8  count of accepted non-R/I instructions.

Function
REQ-020 SHALL drive IF_ID_READY = !ID_EX_VALID || ID_EX_READY, combinationally.
REQ-021 SHALL accept on IF_ID_VALID && IF_ID_READY and load the output register on that edge (one-cycle latency).
REQ-022 SHALL clear ID_EX_VALID on ID_EX_READY without acceptance; SHALL keep it set when consume and accept coincide.
REQ-023 SHALL hold all ID_EX_* outputs stable while ID_EX_VALID && !ID_EX_READY.
REQ-024 SHALL contain 32x32 registers, x0 reading 0 always; WB_WE with WB_ADDR=0 has no effect.
REQ-025 SHALL bypass WB_DATA into RS1/RS2 on acceptance when WB_WE and WB_ADDR matches IR[19:15]/IR[24:20] (nonzero).
REQ-026 SHALL refresh held RS1/RS2 data while stalled when WB_WE writes a matching nonzero source register.
REQ-027 SHALL set ID_EX_IMM = sign-extended IR[31:20] for I_TYPE, 0 otherwise.
REQ-028 SHALL set ID_EX_WB_EN = 1 for R_TYPE/I_TYPE with rd != 0, else 0.
REQ-029 SHALL force RS2 data to 0 for I_TYPE.
REQ-030 SHALL increment ILLEGAL_CNT on each accepted non-R/I opcode, saturating at 255.

Reset
REQ-031 SHALL on rst_n=0 at an edge clear ID_EX_VALID, all ID_EX_* data, ILLEGAL_CNT and all 32 registers to 0.
REQ-032 SHALL drop a held or offered instruction when reset is asserted mid-operation; no acceptance that cycle.
REQ-033 SHALL drive IF_ID_READY=1 in the first cycle after reset release.

Structure
REQ-034 SHALL place opcode constants and the immediate-decode function in a shared package rv32i_pkg.
REQ-035 SHALL implement storage as sub-module rf_2r1w (two combinational read ports, one synchronous write port, x0 hardwired).

Verification
REQ-036 SHALL test: WB writes x5=0x1234, then accept ADD x3,x5,x0 -> RS1=0x00001234, RS2=0, WB_EN=1, RD=3 one cycle later.
REQ-037 SHALL test: accept ADDI x1,x2,-1 with WB_WE x2=7 same cycle -> RS1=7, IMM=0xFFFFFFFF.
REQ-038 SHALL test: ID_EX_READY=0 for 3 cycles, WB writes rs1=0xA5 during stall -> outputs stable except RS1=0xA5; IF_ID_READY=0 throughout.
REQ-039 SHALL test: back-to-back accepts with ID_EX_READY=1 -> ID_EX_VALID stays 1, one entry per cycle.
REQ-040 SHALL test: 300 accepted opcode 7'b1111111 words -> ILLEGAL_CNT=255, WB_EN=0.
REQ-041 SHALL test: rst_n low while ID_EX_VALID=1 -> ID_EX_VALID=0, registers read 0 after release.
